// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// redirect codes (also used by the branch unit) and the default NOP.
package fetch_pkg;

    // Fetch FSM states: one request outstanding at most.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // ready to issue a request
        ST_WAIT = 2'd1,  // request outstanding, waiting for the response
        ST_HOLD = 2'd2,  // response captured, downstream stalled
        ST_DROP = 2'd3   // request outstanding but redirected, discard response
    } fetch_state_t;

    // br_taken encodings; 2'b11 behaves as a trap.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_JUMP = 2'b01;
    localparam logic [1:0] BR_TRAP = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch-PC selection: sequential PC+4, branch target or trap vector.
// Redirect targets are forced to word alignment.
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [31:0] i_pc_f,
    input  logic [1:0]  i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic [31:0] i_trap_vec,
    output logic [31:0] o_pc_next
);

    // Select the source of the next PC from the redirect code.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        o_pc_next = i_pc_f + 32'd4;
        case (i_br_taken)
            BR_NONE: o_pc_next = i_pc_f + 32'd4;
            BR_JUMP: o_pc_next = {i_br_target[31:2], 2'b00};
            BR_TRAP: o_pc_next = {i_trap_vec[31:2], 2'b00};
            default: o_pc_next = {i_trap_vec[31:2], 2'b00};  // 2'b11 acts as a trap
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests
// to instruction memory, loads the IF/EX register and applies redirects by
// flushing IF/EX and discarding any in-flight fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] trap_vec,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_e,
    output logic [31:0] pc_e,
    output logic        valid_e
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc_f;
    logic [31:0] r_hold;
    logic [31:0] r_instr_e;
    logic [31:0] r_pc_e;
    logic        r_valid_e;

    logic [31:0] w_pc_next;
    logic        w_redirect;
    logic        w_load_mem;   // response goes straight into IF/EX
    logic        w_load_hold;  // hold buffer goes into IF/EX
    logic        w_capture;    // response parked in the hold buffer

    assign w_redirect = (br_taken != BR_NONE);

    pc_next_sel u_pc_next_sel (
        .i_pc_f      (r_pc_f),
        .i_br_taken  (br_taken),
        .i_br_target (br_target),
        .i_trap_vec  (trap_vec),
        .o_pc_next   (w_pc_next)
    );

    // Requests only leave IDLE; reset also silences the strobe.
    assign imem_req  = rst_n && (r_state == ST_IDLE) && !stall && !w_redirect;
    assign imem_addr = r_pc_f;

    assign instr_e = r_instr_e;
    assign pc_e    = r_pc_e;
    assign valid_e = r_valid_e;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and datapath strobes; redirect overrides stall everywhere.
    always_comb begin
        w_state_next = r_state;
        w_load_mem   = 1'b0;
        w_load_hold  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_redirect && !stall) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    if (w_redirect) begin
                        w_state_next = ST_IDLE;
                    end else if (stall) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_HOLD;
                    end else begin
                        w_load_mem   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else if (w_redirect) begin
                    w_state_next = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_state_next = ST_IDLE;
                end else if (!stall) begin
                    w_load_hold  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_valid) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Program counter: redirect target, or +4 once an instruction enters IF/EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_f <= RESET_PC;
        end else if (w_redirect || w_load_mem || w_load_hold) begin
            r_pc_f <= w_pc_next;
        end
    end

    // Hold buffer for a response that arrived while downstream was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this single-word buffer is reset so its contents are defined; it is a register, not a memory array.
        if (!rst_n)         r_hold <= 32'h0;
        else if (w_capture) r_hold <= imem_rdata;
    end

    // IF/EX register: flush on redirect, load on accept, freeze on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_e <= NOP_INSTR;
            r_pc_e    <= 32'h0;
            r_valid_e <= 1'b0;
        end else if (w_redirect) begin
            r_instr_e <= NOP_INSTR;
            r_valid_e <= 1'b0;
        end else if (w_load_mem) begin
            r_instr_e <= imem_rdata;
            r_pc_e    <= r_pc_f;
            r_valid_e <= 1'b1;
        end else if (w_load_hold) begin
            r_instr_e <= r_hold;
            r_pc_e    <= r_pc_f;
            r_valid_e <= 1'b1;
        end else if (!stall) begin
            r_valid_e <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized stall/redirect/latency traffic, checked against a
// transaction-level model of the fetch contract.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  br_taken = 2'b00;
    logic [31:0] br_target = 32'h0;
    logic [31:0] trap_vec = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_e;
    logic [31:0] pc_e;
    logic        valid_e;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (TB_RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .trap_vec   (trap_vec),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .instr_e    (instr_e),
        .pc_e       (pc_e),
        .valid_e    (valid_e)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding request, held response, expected fetch PC, expected IF/EX.
    bit          m_out, m_killed, m_held;
    logic [31:0] m_out_addr, m_held_addr, m_fetch;
    logic [31:0] e_instr, e_pc;
    logic        e_valid;

    // Memory model.
    bit          mem_busy;
    int          mem_cnt;
    int          mem_lat = 1;
    logic [31:0] mem_addr;
    bit          mem_const = 1'b0;
    logic [31:0] last_req_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_const) return 32'h0010_0093;
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    // One clock cycle: drive inputs, check request, advance model, check IF/EX.
    task automatic cycle(input bit st, input logic [1:0] br, input logic [31:0] tgt, input logic [31:0] tv);
        bit          exp_req, redir, deliver;
        logic [31:0] da;
        @(negedge clk);
        stall = st; br_taken = br; br_target = tgt; trap_vec = tv;
        if (mem_busy && mem_cnt == 1) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(mem_addr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        redir   = (br != 2'b00);
        exp_req = !m_out && !m_held && !st && !redir;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_fetch);

        deliver = 1'b0;
        da      = 32'h0;
        if (redir) begin
            m_fetch = ((br == BR_JUMP) ? tgt : tv) & ~32'h3;
            e_valid = 1'b0;
            e_instr = NOP;
            if (m_out && imem_valid) begin
                m_out = 1'b0; m_killed = 1'b0;
            end else if (m_out) begin
                m_killed = 1'b1;
            end
            m_held = 1'b0;
        end else begin
            if (m_out && imem_valid) begin
                m_out = 1'b0;
                if (m_killed) m_killed = 1'b0;
                else if (!st) begin deliver = 1'b1; da = m_out_addr; end
                else begin m_held = 1'b1; m_held_addr = m_out_addr; end
            end else if (m_held && !st) begin
                deliver = 1'b1; da = m_held_addr; m_held = 1'b0;
            end
            if (deliver) begin
                e_valid = 1'b1; e_pc = da; e_instr = mem_word(da); m_fetch = da + 32'd4;
            end else if (!st) begin
                e_valid = 1'b0;
            end
        end
        if (exp_req) begin
            m_out = 1'b1; m_out_addr = m_fetch; m_killed = 1'b0;
        end

        if (imem_valid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (imem_req) begin
            mem_busy = 1'b1; mem_cnt = mem_lat; mem_addr = imem_addr; last_req_addr = imem_addr;
        end

        @(posedge clk);
        #1;
        check("valid_e", 32'(valid_e), 32'(e_valid));
        check("instr_e", instr_e, e_instr);
        check("pc_e", pc_e, e_pc);
    endtask

    // Asynchronous reset pulse mid-cycle; memory and model are reset with it.
    task automatic do_reset();
        #2;
        rst_n = 1'b0; stall = 1'b0; br_taken = 2'b00; imem_valid = 1'b0;
        #1;
        check("rst_valid_e", 32'(valid_e), 32'd0);
        check("rst_instr_e", instr_e, NOP);
        check("rst_pc_e", pc_e, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, TB_RESET_PC);
        m_out = 1'b0; m_killed = 1'b0; m_held = 1'b0;
        m_fetch = TB_RESET_PC;
        e_valid = 1'b0; e_instr = NOP; e_pc = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0;
        last_req_addr = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Let any outstanding or held fetch complete, bounded.
    task automatic drain();
        for (int i = 0; i < 20 && (m_out || m_held); i++) cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("drain_timeout", 32'(m_out | m_held), 32'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset and 1-cycle memory with a constant instruction.
        mem_const = 1'b1;
        mem_lat   = 1;
        do_reset();
        repeat (6) cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t1_third_req", last_req_addr, 32'h8);
        check("t1_last_pc_e", pc_e, 32'h8);
        check("t1_last_instr", instr_e, 32'h0010_0093);
        mem_const = 1'b0;

        // Response for 0x10 arrives under a 3-cycle stall.
        drain();
        cycle(1'b0, BR_JUMP, 32'h10, 32'h0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) cycle(1'b1, 2'b00, 32'h0, 32'h0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t2_pc_e", pc_e, 32'h10);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t2_next_req", last_req_addr, 32'h14);

        // Jump while waiting on a 3-cycle memory.
        drain();
        mem_lat = 3;
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        cycle(1'b0, BR_JUMP, 32'h0000_0203, 32'h0);
        check("t3_flush_instr", instr_e, NOP);
        repeat (3) cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t3_target_req", last_req_addr, 32'h200);

        // Trap while in HOLD with stall high.
        mem_lat = 1;
        drain();
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        cycle(1'b1, 2'b00, 32'h0, 32'h0);
        cycle(1'b1, BR_TRAP, 32'h0, 32'h80);
        check("t4_flush_valid", 32'(valid_e), 32'd0);
        cycle(1'b1, 2'b00, 32'h0, 32'h0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t4_trap_req", last_req_addr, 32'h80);

        // Code 2'b11 acts as a trap.
        drain();
        cycle(1'b0, 2'b11, 32'h40, 32'h80);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t5_br11_req", last_req_addr, 32'h80);

        // PC wrap-around.
        drain();
        cycle(1'b0, BR_JUMP, 32'hFFFF_FFFC, 32'h0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t6_wrap_pc_e", pc_e, 32'hFFFF_FFFC);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t6_wrap_req", last_req_addr, 32'h0);

        // Reset in WAIT abandons the request.
        drain();
        mem_lat = 3;
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        do_reset();
        cycle(1'b0, 2'b00, 32'h0, 32'h0);
        check("t7_reset_req", last_req_addr, TB_RESET_PC);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [1:0]  br;
            mem_lat = int'($urandom_range(1, 4));
            r  = int'($urandom_range(0, 15));
            br = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle($urandom_range(0, 9) < 3, br, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the three-stage pipeline and the direct consumer of the branch-resolution `br_taken` code. It owns the program counter and issues single-outstanding requests to instruction memory. It loads the IF/EX pipeline register and applies branch/jump and trap redirects by flushing that register and discarding any in-flight fetch.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction written to `instr_e` on reset or flush (`addi x0,x0,0`).

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `br_taken`, in, 2: redirect code. 2'b00 none, 2'b01 branch/jump, 2'b10 trap/interrupt, 2'b11 treated as 2'b10.
- `br_target`, in, 32: branch/jump target from execute.
- `trap_vec`, in, 32: trap vector or return address from the CSR file.
- `stall`, in, 1: downstream cannot accept a new instruction this cycle.
- `imem_req`, out, 1: request strobe, asserted for exactly one cycle per request.
- `imem_addr`, out, 32: fetch address, valid when `imem_req` is high.
- `imem_valid`, in, 1: response strobe, at least 1 cycle after the request.
- `imem_rdata`, in, 32: instruction, valid when `imem_valid` is high.
- `instr_e`, out, 32: IF/EX register, instruction.
- `pc_e`, out, 32: IF/EX register, PC of `instr_e`.
- `valid_e`, out, 1: IF/EX register holds a real instruction.

## Operation

- State register `pc_f`, 32 bits. FSM states are IDLE, WAIT, HOLD and DROP. At most one request is outstanding.
- IDLE: if `!stall` and no redirect, drive `imem_req=1` and `imem_addr=pc_f`, then go to WAIT. Otherwise stay in IDLE with `imem_req=0`.
- WAIT, `imem_valid`, no redirect, `!stall`: load `instr_e<=imem_rdata`, `pc_e<=pc_f`, `valid_e<=1`, `pc_f<=pc_f+4`, go to IDLE.
- WAIT, `imem_valid`, no redirect, `stall`: capture `imem_rdata` in the hold buffer and go to HOLD. The IF/EX register is unchanged.
- HOLD: when `!stall`, transfer the hold buffer to IF/EX as above, set `pc_f<=pc_f+4`, go to IDLE.
- DROP: wait for `imem_valid`, discard `imem_rdata`, go to IDLE.
- Redirect (`br_taken!=0`) is evaluated every cycle and overrides `stall`. It has the following effects:
  - `pc_f` is loaded with `br_target` (01) or `trap_vec` (1x), with bits [1:0] forced to 0.
  - IF/EX is flushed: `valid_e<=0`, `instr_e<=NOP_INSTR`, `pc_e` is held.
  - Next state depends on the current state. IDLE goes to IDLE with no request issued this cycle. WAIT without `imem_valid` goes to DROP. WAIT with `imem_valid` discards the response and goes to IDLE. HOLD discards the buffer and goes to IDLE. DROP without `imem_valid` stays in DROP; DROP with `imem_valid` goes to IDLE.
- `stall` with no redirect freezes the IF/EX register.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing

- Reset values: `pc_f=RESET_PC`, state IDLE, `imem_req=0`, `imem_addr=RESET_PC`, `instr_e=NOP_INSTR`, `pc_e=0`, `valid_e=0`, hold buffer 0.
- The first request is issued in the first cycle after `rst_n` deasserts with `stall` low.
- `imem_req` and `imem_addr` are combinational from state, `pc_f`, `stall` and `br_taken`.
- Best-case throughput is one instruction per 2 cycles with a 1-cycle memory.
- Latency from `imem_valid` to `valid_e`: registered, visible the next cycle; from HOLD, the cycle after `stall` falls.
- A redirect in cycle N means the request to the target issues in cycle N+1 if not in DROP. Otherwise it issues the cycle after the discarded `imem_valid`.
- Asserting `rst_n` low mid-transaction abandons the outstanding request. A late `imem_valid` after reset must not load IF/EX; the bench guarantees the memory is also reset.

## Structure

- `fetch_pkg` holds the following:
  - the FSM enum `fetch_state_t`;
  - `BR_NONE`, `BR_JUMP`, `BR_TRAP` encodings of `br_taken`, shared with the branch unit;
  - the `NOP_INSTR` default.
- One combinational sub-module, `pc_next_sel`, selects between `pc_f+4`, `br_target` and `trap_vec` from `br_taken` and performs the bit [1:0] clear. The FSM, hold buffer and IF/EX register live in `fetch_stage`.

## Test plan

- Reset with `RESET_PC`=0 and a 1-cycle memory returning 32'h0010_0093, no stall: `imem_addr` sequence 0, 4, 8. `valid_e` pulses with `pc_e`=0, 4, 8 and `instr_e`=32'h0010_0093.
- `stall` high for 3 cycles when `imem_valid` arrives for PC 0x10: FSM enters HOLD with no new `imem_req`. `valid_e` with `pc_e=0x10` appears the cycle after `stall` falls, and the next request is to 0x14.
- `br_taken=01`, `br_target=0x0000_0203` while in WAIT with a 3-cycle memory: `valid_e=0` and `instr_e=NOP_INSTR` next cycle. The late response is discarded and the next `imem_addr` is 0x200.
- `br_taken=10`, `trap_vec=0x80`, with `stall=1` and in HOLD: buffer dropped, IF/EX flushed, next request to 0x80 despite the earlier stall once `stall` falls.
- `br_taken=11` with `br_target=0x40` and `trap_vec=0x80`: redirect goes to 0x80.
- `pc_f=0xFFFF_FFFC` fetch accepted: next `imem_addr` is 0x0000_0000. `rst_n` pulsed low in WAIT: outputs return to reset values immediately and the next request is to `RESET_PC`.
